// File: rtl/ps2_mouse_paddle_decoder.sv
// ps2_mouse_paddle_decoder
//   Receives raw PS/2 mouse frames, assembles 3-byte movement packets and
//   turns the Y movement into a paddle speed/direction for the physics block.
//   Everything runs in the clk_25MHz domain.
//
// Ports:
//   clk_25MHz      system clock
//   reset          asynchronous, active-high reset
//   ps2_clk        raw PS/2 clock (asynchronous, synchronized here)
//   ps2_data       raw PS/2 data  (asynchronous, synchronized here)
//   paddle0_speed  |Y| of the last accepted packet, saturated to 255
//   paddle0_dir    1 = up (Y >= 0), 0 = down (Y < 0)
//   new_data       high for NEW_DATA_CYCLES cycles after each accepted packet
//   frame_err      one-cycle pulse on framing, parity, sync-bit or timeout error
//
// Build option:
//   PS2_PARITY_CHECK_EN  when defined, a bad odd-parity bit rejects the byte;
//                        otherwise the parity bit is consumed but ignored.
module ps2_mouse_paddle_decoder #(
   parameter int unsigned NEW_DATA_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 25000,
   parameter int unsigned TIMEOUT_W       = 15
) (
   input  logic       clk_25MHz,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] paddle0_speed,
   output logic       paddle0_dir,
   output logic       new_data,
   output logic       frame_err
);

   localparam int unsigned ND_W = (NEW_DATA_CYCLES > 2) ? $clog2(NEW_DATA_CYCLES) : 1;

   typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_st_t;
   typedef enum logic [1:0] {P_B0, P_B1, P_B2} pkt_st_t;

   logic                 ps2c_meta_q, ps2c_meta_d, ps2c_sync_q, ps2c_sync_d;
   logic                 ps2c_prev_q, ps2c_prev_d;
   logic                 ps2d_meta_q, ps2d_meta_d, ps2d_sync_q, ps2d_sync_d;
   frame_st_t            frame_st_q, frame_st_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           shift_q, shift_d;
`ifdef PS2_PARITY_CHECK_EN
   logic                 par_q, par_d;
`endif
   logic                 byte_vld_q, byte_vld_d;
   pkt_st_t              pkt_st_q, pkt_st_d;
   logic                 y_sign_q, y_sign_d, y_ovf_q, y_ovf_d;
   logic [TIMEOUT_W-1:0] to_cnt_q, to_cnt_d;
   logic [7:0]           speed_q, speed_d;
   logic                 dir_q, dir_d;
   logic                 load_q, load_d;
   logic                 nd_q, nd_d;
   logic [ND_W-1:0]      nd_cnt_q, nd_cnt_d;
   logic                 err_q, err_d;

   logic                 fedge, par_ok, to_hit;
   logic [8:0]           y9, ymag;

   assign fedge = ps2c_prev_q & ~ps2c_sync_q;
   assign to_hit = (to_cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES));

   // Y is 9-bit two's complement; negating -256 stays 0x100, which saturates.
   assign y9   = {y_sign_q, shift_q};
   assign ymag = y_sign_q ? (~y9 + 9'd1) : y9;

`ifdef PS2_PARITY_CHECK_EN
   assign par_ok = ^{shift_q, par_q};
`else
   assign par_ok = 1'b1;
`endif

   always_comb begin
      ps2c_meta_d = ps2_clk;
      ps2c_sync_d = ps2c_meta_q;
      ps2c_prev_d = ps2c_sync_q;
      ps2d_meta_d = ps2_data;
      ps2d_sync_d = ps2d_meta_q;
      frame_st_d  = frame_st_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
`ifdef PS2_PARITY_CHECK_EN
      par_d       = par_q;
`endif
      byte_vld_d  = 1'b0;
      pkt_st_d    = pkt_st_q;
      y_sign_d    = y_sign_q;
      y_ovf_d     = y_ovf_q;
      to_cnt_d    = to_cnt_q;
      speed_d     = speed_q;
      dir_d       = dir_q;
      load_d      = 1'b0;
      nd_d        = nd_q;
      nd_cnt_d    = nd_cnt_q;
      err_d       = 1'b0;

      // Frame receiver, one step per PS/2 falling edge.
      if (fedge) begin
         case (frame_st_q)
            F_IDLE: begin
               if (!ps2d_sync_q) begin
                  frame_st_d = F_DATA;
                  bit_cnt_d  = '0;
               end
            end
            F_DATA: begin
               shift_d   = {ps2d_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) frame_st_d = F_PARITY;
            end
            F_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
               par_d = ps2d_sync_q;
`endif
               frame_st_d = F_STOP;
            end
            F_STOP: begin
               frame_st_d = F_IDLE;
               if (ps2d_sync_q && par_ok) begin
                  byte_vld_d = 1'b1;
               end else begin
                  err_d    = 1'b1;
                  pkt_st_d = P_B0;
               end
            end
            default: frame_st_d = F_IDLE;
         endcase
      end

      // Packet assembler; shift_q still holds the byte while byte_vld_q is high.
      if (byte_vld_q) begin
         case (pkt_st_q)
            P_B0: begin
               if (shift_q[3]) begin
                  y_sign_d = shift_q[5];
                  y_ovf_d  = shift_q[7];
                  pkt_st_d = P_B1;
               end else begin
                  err_d = 1'b1;
               end
            end
            P_B1: pkt_st_d = P_B2;
            P_B2: begin
               pkt_st_d = P_B0;
               // A packet finishing while new_data is still being announced is dropped.
               if (!nd_q && !load_q) begin
                  speed_d = (y_ovf_q || ymag[8]) ? 8'hFF : ymag[7:0];
                  dir_d   = ~y_sign_q;
                  load_d  = 1'b1;
               end
            end
            default: pkt_st_d = P_B0;
         endcase
      end

      // Idle watchdog: saturates, restarts on every PS/2 falling edge.
      if (fedge) begin
         to_cnt_d = '0;
      end else if (!to_hit) begin
         to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
      end else if (frame_st_q != F_IDLE || pkt_st_q != P_B0) begin
         frame_st_d = F_IDLE;
         pkt_st_d   = P_B0;
         err_d      = 1'b1;
      end

      // new_data rises the cycle after the outputs load.
      if (load_q) begin
         nd_d     = 1'b1;
         nd_cnt_d = ND_W'(NEW_DATA_CYCLES - 1);
      end else if (nd_q) begin
         if (nd_cnt_q == '0) nd_d = 1'b0;
         else                nd_cnt_d = nd_cnt_q - ND_W'(1);
      end
   end

   always_ff @(posedge clk_25MHz or posedge reset) begin
      if (reset) begin
         ps2c_meta_q <= 1'b1;
         ps2c_sync_q <= 1'b1;
         ps2c_prev_q <= 1'b1;
         ps2d_meta_q <= 1'b1;
         ps2d_sync_q <= 1'b1;
         frame_st_q  <= F_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= 1'b0;
`endif
         byte_vld_q  <= 1'b0;
         pkt_st_q    <= P_B0;
         y_sign_q    <= 1'b0;
         y_ovf_q     <= 1'b0;
         to_cnt_q    <= '0;
         speed_q     <= '0;
         dir_q       <= 1'b1;
         load_q      <= 1'b0;
         nd_q        <= 1'b0;
         nd_cnt_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         ps2c_meta_q <= ps2c_meta_d;
         ps2c_sync_q <= ps2c_sync_d;
         ps2c_prev_q <= ps2c_prev_d;
         ps2d_meta_q <= ps2d_meta_d;
         ps2d_sync_q <= ps2d_sync_d;
         frame_st_q  <= frame_st_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
`ifdef PS2_PARITY_CHECK_EN
         par_q       <= par_d;
`endif
         byte_vld_q  <= byte_vld_d;
         pkt_st_q    <= pkt_st_d;
         y_sign_q    <= y_sign_d;
         y_ovf_q     <= y_ovf_d;
         to_cnt_q    <= to_cnt_d;
         speed_q     <= speed_d;
         dir_q       <= dir_d;
         load_q      <= load_d;
         nd_q        <= nd_d;
         nd_cnt_q    <= nd_cnt_d;
         err_q       <= err_d;
      end
   end

   assign paddle0_speed = speed_q;
   assign paddle0_dir   = dir_q;
   assign new_data      = nd_q;
   assign frame_err     = err_q;

endmodule

// File: tb/tb_ps2_mouse_paddle_decoder.sv
// Testbench for ps2_mouse_paddle_decoder: directed and random PS/2 packets
// compared against a byte-level integer model of the packet rules.
module tb_ps2_mouse_paddle_decoder;

   localparam int HALF = 20;   // PS/2 half bit period in system clocks
   localparam int GAP  = 60;   // idle clocks between bytes
   localparam int TO   = 500;  // timeout used by this bench
   localparam int NDC  = 4;

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_CHK = 1'b1;
`else
   localparam bit PAR_CHK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] paddle0_speed;
   logic       paddle0_dir;
   logic       new_data;
   logic       frame_err;

   ps2_mouse_paddle_decoder #(
      .NEW_DATA_CYCLES(NDC),
      .TIMEOUT_CYCLES (TO),
      .TIMEOUT_W      (15)
   ) dut (
      .clk_25MHz    (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .paddle0_speed(paddle0_speed),
      .paddle0_dir  (paddle0_dir),
      .new_data     (new_data),
      .frame_err    (frame_err)
   );

   always #20 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state
   int m_idx = 0;
   bit m_sign, m_ovf;
   int exp_speed = 0, exp_dir = 1, exp_err = 0, exp_nd = 0;

   task automatic model_byte(input logic [7:0] b, input bit ok);
      int y, mag;
      if (!ok) begin
         exp_err++;
         m_idx = 0;
      end else if (m_idx == 0) begin
         if (b[3]) begin
            m_sign = b[5];
            m_ovf  = b[7];
            m_idx  = 1;
         end else begin
            exp_err++;
         end
      end else if (m_idx == 1) begin
         m_idx = 2;
      end else begin
         y   = m_sign ? int'(b) - 256 : int'(b);
         mag = (y < 0) ? -y : y;
         exp_speed = (m_ovf || mag > 255) ? 255 : mag;
         exp_dir   = (y >= 0) ? 1 : 0;
         exp_nd++;
         m_idx = 0;
      end
   endtask

   // Monitor of DUT pulses
   int err_seen = 0, nd_seen = 0, nd_w = 0;
   logic       prev_nd = 1'b0;
   logic [8:0] prev_out = 9'h100;

   always @(negedge clk) begin
      if (reset) begin
         nd_w     = 0;
         prev_nd  = 1'b0;
         prev_out = {paddle0_dir, paddle0_speed};
      end else begin
         if (frame_err) err_seen++;
         if (new_data && !prev_nd) begin
            nd_seen++;
            chk("nd_setup", int'({paddle0_dir, paddle0_speed}), int'(prev_out));
         end
         if (new_data) nd_w++;
         if (!new_data && prev_nd) begin
            chk("nd_width", nd_w, NDC);
            nd_w = 0;
         end
         prev_nd  = new_data;
         prev_out = {paddle0_dir, paddle0_speed};
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic ps2_bit(input bit b);
      ps2_data = b;
      idle(HALF);
      ps2_clk = 1'b0;
      idle(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit((~^b) ^ bad_par);
      ps2_bit(~bad_stop);
      ps2_data = 1'b1;
      model_byte(b, !bad_stop && !(PAR_CHK && bad_par));
      idle(GAP);
   endtask

   task automatic idle_timeout();
      idle(TO + 100);
      if (m_idx != 0) exp_err++;
      m_idx = 0;
   endtask

   task automatic partial_frame(input int nbits);
      ps2_bit(1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom));
      ps2_data = 1'b1;
      idle(TO + 100);
      exp_err++;
      m_idx = 0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_speed"}, int'(paddle0_speed), exp_speed);
      chk({tag, "_dir"}, int'(paddle0_dir), exp_dir);
      chk({tag, "_errs"}, err_seen, exp_err);
      chk({tag, "_pkts"}, nd_seen, exp_nd);
   endtask

   task automatic pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input string tag);
      send_byte(b0, 1'b0, 1'b0);
      send_byte(b1, 1'b0, 1'b0);
      send_byte(b2, 1'b0, 1'b0);
      check_state(tag);
   endtask

   initial begin
      logic [7:0] bytes [3];
      logic [7:0] bs;
      int kind, pos;

      idle(5);
      @(negedge clk);
      chk("rst_speed", int'(paddle0_speed), 0);
      chk("rst_dir", int'(paddle0_dir), 1);
      chk("rst_nd", int'(new_data), 0);
      chk("rst_err", int'(frame_err), 0);
      reset = 1'b0;

      idle(1000);
      check_state("idle");

      pkt(8'h08, 8'h00, 8'h0A, "yp10");
      pkt(8'h28, 8'h05, 8'hF0, "ym16");
      pkt(8'h28, 8'h00, 8'h00, "ym256");
      pkt(8'hC8, 8'h00, 8'h01, "ovf");
      pkt(8'h08, 8'h00, 8'h00, "y0");

      send_byte(8'h00, 1'b0, 1'b0);
      pkt(8'h08, 8'h00, 8'h03, "resync");

      send_byte(8'h08, 1'b1, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      send_byte(8'h05, 1'b0, 1'b0);
      check_state("badpar");

      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b1);
      send_byte(8'h09, 1'b0, 1'b0);
      check_state("badstop");
      idle_timeout();
      check_state("stop_to");

      send_byte(8'h08, 1'b0, 1'b0);
      send_byte(8'h00, 1'b0, 1'b0);
      idle_timeout();
      check_state("timeout");
      idle(TO + 100);
      check_state("idle_to");
      partial_frame(4);
      check_state("partial");
      pkt(8'h38, 8'h11, 8'h9C, "after_to");

      for (int p = 0; p < 20; p++) begin
         bytes[0] = 8'($urandom);
         bytes[0][3] = 1'b1;
         bytes[0][7] = ($urandom_range(0, 5) == 0);
         bytes[1] = 8'($urandom);
         bytes[2] = 8'($urandom);
         kind = int'($urandom_range(0, 7));
         pos  = int'($urandom_range(0, 2));
         if (kind == 0) begin
            bs = 8'($urandom);
            bs[3] = 1'b0;
            send_byte(bs, 1'b0, 1'b0);
         end
         if (kind == 3) begin
            send_byte(bytes[0], 1'b0, 1'b0);
            send_byte(bytes[1], 1'b0, 1'b0);
            idle_timeout();
         end
         for (int i = 0; i < 3; i++)
            send_byte(bytes[i], (kind == 2) && (i == pos), (kind == 1) && (i == pos));
         check_state("rand");
      end
      idle_timeout();
      check_state("rand_end");

      pkt(8'h08, 8'h00, 8'h2A, "pre_rst");
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      reset = 1'b1;
      #1;
      chk("mid_rst_speed", int'(paddle0_speed), 0);
      chk("mid_rst_dir", int'(paddle0_dir), 1);
      chk("mid_rst_nd", int'(new_data), 0);
      ps2_data = 1'b1;
      m_idx = 0;
      exp_speed = 0;
      exp_dir = 1;
      idle(5);
      reset = 1'b0;
      idle(GAP);
      check_state("post_rst");
      pkt(8'h28, 8'h00, 8'h80, "recover");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
